// File: rtl/cache_fill_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module   : cache_fill_fsm_if
//  Function : Requester, memory-port and cache-array signals of one line fill.
//  Revision : 1.0 - initial release
// ============================================================================
interface cache_fill_fsm_if;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        fsm_busy;
  logic        memory_read_en;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic        write_tag_array;
  logic [15:0] cache_addr;
  logic [15:0] cache_data_in;
  logic [7:0]  tag_out;

  // Fill controller side
  modport slave (
    input  miss_detected, miss_address, memory_data_valid, memory_data,
    output fsm_busy, memory_read_en, memory_address, write_data_array,
           write_tag_array, cache_addr, cache_data_in, tag_out
  );

  // Cache core / memory side
  modport master (
    output miss_detected, miss_address, memory_data_valid, memory_data,
    input  fsm_busy, memory_read_en, memory_address, write_data_array,
           write_tag_array, cache_addr, cache_data_in, tag_out
  );
endinterface
`default_nettype wire

// File: rtl/cache_fill_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : cache_fill_fsm
//  Function : Cache miss handler; fetches an 8-word line with pipelined reads,
//             writes each word into the data array, then installs the tag.
//  Revision : 1.0 - initial release
// ============================================================================
module cache_fill_fsm (
  input  wire logic       clk,
  input  wire logic       rst,
  cache_fill_fsm_if.slave fill_if
);

  localparam logic [3:0] c_WORDS_PER_LINE = 4'd8;
  localparam logic [3:0] c_LAST_WORD      = 4'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_TAG  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_base;
  logic [3:0]  r_issue_cnt;
  logic [3:0]  r_recv_cnt;

  logic        w_busy;
  logic        w_read_en;
  logic [15:0] w_mem_addr;
  logic        w_wr_data;
  logic        w_wr_tag;
  logic [15:0] w_cache_addr;
  logic [15:0] w_cache_din;
  logic [7:0]  w_tag_out;

  always_comb begin
    w_next       = r_state;
    w_busy       = 1'b0;
    w_read_en    = 1'b0;
    w_mem_addr   = 16'h0000;
    w_wr_data    = 1'b0;
    w_wr_tag     = 1'b0;
    w_cache_addr = 16'h0000;
    w_cache_din  = 16'h0000;
    w_tag_out    = 8'h00;
    case (r_state)
      S_IDLE: begin
        // Stall is combinational so the pipeline freezes in the miss cycle.
        w_busy = fill_if.miss_detected;
        if (fill_if.miss_detected) begin
          w_next = S_FILL;
        end
      end
      S_FILL: begin
        w_busy    = 1'b1;
        w_read_en = (r_issue_cnt < c_WORDS_PER_LINE);
        if (w_read_en) begin
          w_mem_addr = r_base + {11'd0, r_issue_cnt, 1'b0};
        end
        if (fill_if.memory_data_valid) begin
          w_wr_data    = 1'b1;
          w_cache_addr = r_base + {11'd0, r_recv_cnt, 1'b0};
          w_cache_din  = fill_if.memory_data;
          if (r_recv_cnt == c_LAST_WORD) begin
            w_next = S_TAG;
          end
        end
      end
      S_TAG: begin
        w_busy       = 1'b1;
        w_wr_tag     = 1'b1;
        w_cache_addr = r_base;
        w_tag_out    = {r_base[15:10], 1'b1, 1'b0};
        w_next       = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_base      <= 16'h0000;
      r_issue_cnt <= 4'd0;
      r_recv_cnt  <= 4'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (fill_if.miss_detected) begin
            r_base      <= fill_if.miss_address & 16'hFFF0;
            r_issue_cnt <= 4'd0;
            r_recv_cnt  <= 4'd0;
          end
        end
        S_FILL: begin
          if (w_read_en) begin
            r_issue_cnt <= r_issue_cnt + 4'd1;
          end
          if (w_wr_data) begin
            r_recv_cnt <= r_recv_cnt + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign fill_if.fsm_busy         = w_busy;
  assign fill_if.memory_read_en   = w_read_en;
  assign fill_if.memory_address   = w_mem_addr;
  assign fill_if.write_data_array = w_wr_data;
  assign fill_if.write_tag_array  = w_wr_tag;
  assign fill_if.cache_addr       = w_cache_addr;
  assign fill_if.cache_data_in    = w_cache_din;
  assign fill_if.tag_out          = w_tag_out;

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cache_fill_fsm
//  Function : Self-checking bench for cache_fill_fsm with a pipelined memory.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cache_fill_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_fill_fsm_if bus ();

  cache_fill_fsm dut (
    .clk     (clk),
    .rst     (rst),
    .fill_if (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Behavioural model: mode 0 idle, 1 filling, 2 tag write
  int          m_mode = 0;
  int          m_k    = 0;
  int          m_recv = 0;
  logic [15:0] m_base = 16'h0000;

  typedef struct {
    int          due;
    logic [15:0] addr;
  } req_t;
  req_t pend[$];
  int   last_due = -1;
  bit   rand_lat = 1'b0;

  logic [15:0] req_log[$];
  logic [15:0] wr_addr_log[$];
  logic [15:0] wr_data_log[$];
  logic [15:0] tag_log[$];
  int busy_cnt, tag_cyc, first_req_cyc, first_wr_cyc, both_cnt;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_logs();
    req_log.delete(); wr_addr_log.delete(); wr_data_log.delete(); tag_log.delete();
    busy_cnt = 0; tag_cyc = -1; first_req_cyc = -1; first_wr_cyc = -1;
  endtask

  task automatic cycle(input logic i_miss, input logic [15:0] i_addr,
                       input logic i_stray, input logic i_rst);
    logic        v;
    logic [15:0] d;
    logic        e_busy, e_rd, e_wd, e_wt;
    logic [15:0] e_maddr, e_caddr, e_din;
    logic [7:0]  e_tag;
    int          lat;
    #1;
    rst                   = i_rst;
    bus.miss_detected     = i_miss;
    bus.miss_address      = i_addr;
    v = 1'b0;
    d = 16'h0000;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      v = 1'b1;
      d = 16'hA000 + {12'h000, pend[0].addr[3:0]};
      void'(pend.pop_front());
    end
    if (i_stray) begin
      v = 1'b1;
      d = 16'h5A5A;
    end
    bus.memory_data_valid = v;
    bus.memory_data       = d;
    #1;
    e_busy = 1'b0; e_rd = 1'b0; e_wd = 1'b0; e_wt = 1'b0;
    e_maddr = 16'h0; e_caddr = 16'h0; e_din = 16'h0; e_tag = 8'h0;
    case (m_mode)
      0: e_busy = i_miss;
      1: begin
        e_busy = 1'b1;
        e_rd   = (m_k <= 8);
        if (e_rd) e_maddr = m_base + 16'(2 * (m_k - 1));
        if (v) begin
          e_wd    = 1'b1;
          e_caddr = m_base + 16'(2 * m_recv);
          e_din   = d;
        end
      end
      default: begin
        e_busy  = 1'b1;
        e_wt    = 1'b1;
        e_caddr = m_base;
        e_tag   = {m_base[15:10], 2'b10};
      end
    endcase
    check("fsm_busy",         16'(bus.fsm_busy),         16'(e_busy));
    check("memory_read_en",   16'(bus.memory_read_en),   16'(e_rd));
    check("memory_address",   bus.memory_address,        e_maddr);
    check("write_data_array", 16'(bus.write_data_array), 16'(e_wd));
    check("write_tag_array",  16'(bus.write_tag_array),  16'(e_wt));
    check("cache_addr",       bus.cache_addr,            e_caddr);
    check("cache_data_in",    bus.cache_data_in,         e_din);
    check("tag_out",          16'(bus.tag_out),          16'(e_tag));

    if (bus.memory_read_en === 1'b1) begin
      lat = rand_lat ? int'($urandom_range(4, 7)) : 4;
      if (cyc + lat <= last_due) lat = last_due + 1 - cyc;
      last_due = cyc + lat;
      pend.push_back('{due: last_due, addr: bus.memory_address});
      req_log.push_back(bus.memory_address);
      if (first_req_cyc < 0) first_req_cyc = cyc;
    end
    if (bus.fsm_busy === 1'b1) busy_cnt++;
    if (bus.write_data_array === 1'b1) begin
      wr_addr_log.push_back(bus.cache_addr);
      wr_data_log.push_back(bus.cache_data_in);
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
    end
    if (bus.write_tag_array === 1'b1) begin
      tag_log.push_back(16'(bus.tag_out));
      tag_cyc = cyc;
    end
    if (bus.write_data_array === 1'b1 && bus.write_tag_array === 1'b1) both_cnt++;

    @(posedge clk);
    cyc++;
    if (i_rst) begin
      m_mode = 0; m_k = 0; m_recv = 0; m_base = 16'h0000;
    end else begin
      case (m_mode)
        0: if (i_miss) begin
          m_mode = 1; m_k = 1; m_recv = 0; m_base = i_addr & 16'hFFF0;
        end
        1: begin
          m_k++;
          if (v) begin
            m_recv++;
            if (m_recv == 8) m_mode = 2;
          end
        end
        default: m_mode = 0;
      endcase
    end
  endtask

  // One miss, then run until the model returns to idle; miss held or dropped.
  task automatic run_fill(input logic [15:0] addr, input logic hold);
    int g;
    g = 0;
    cycle(1'b1, addr, 1'b0, 1'b0);
    while (m_mode != 0 && g < 200) begin
      cycle(hold, addr, 1'b0, 1'b0);
      g++;
    end
    if (g >= 200) begin
      n_vec++; n_err++;
      $display("FAIL fill_timeout: fill at %h still busy after %0d cycles, expected idle", addr, g);
    end
  endtask

  initial begin
    int t0, g, gap;
    logic [15:0] ra;
    bus.miss_detected = 1'b0; bus.miss_address = 16'h0;
    bus.memory_data_valid = 1'b0; bus.memory_data = 16'h0;
    both_cnt = 0;
    clear_logs();
    @(posedge clk);

    // Reset then idle
    cycle(1'b0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) cycle(1'b0, 16'h0, 1'b0, 1'b0);
    check("idle_requests", 16'(req_log.size()), 16'd0);
    check("idle_busy",     16'(busy_cnt),       16'd0);

    // Single fill at 0x1236
    clear_logs();
    t0 = cyc;
    run_fill(16'h1236, 1'b1);
    check("fill_req_count", 16'(req_log.size()), 16'd8);
    if (req_log.size() == 8) begin
      check("fill_req_first", req_log[0], 16'h1230);
      check("fill_req_last",  req_log[7], 16'h123E);
    end
    check("fill_req_start", 16'(first_req_cyc - t0), 16'd1);
    check("fill_wr_start",  16'(first_wr_cyc - t0),  16'd5);
    check("fill_wr_count",  16'(wr_addr_log.size()), 16'd8);
    if (wr_addr_log.size() == 8) begin
      check("fill_wr_addr_last", wr_addr_log[7], 16'h123E);
      check("fill_wr_data_0",    wr_data_log[0], 16'hA000);
      check("fill_wr_data_7",    wr_data_log[7], 16'hA00E);
    end
    check("fill_tag_cycle", 16'(tag_cyc - t0), 16'd13);
    check("fill_tag_count", 16'(tag_log.size()), 16'd1);
    if (tag_log.size() == 1) check("fill_tag_value", tag_log[0], 16'h0012);
    check("fill_busy_cycles", 16'(busy_cnt), 16'd14);
    cycle(1'b0, 16'h0, 1'b0, 1'b0);

    // Stray valid in idle
    clear_logs();
    cycle(1'b0, 16'h0, 1'b1, 1'b0);
    check("stray_no_write", 16'(wr_addr_log.size()), 16'd0);
    run_fill(16'h4C2A, 1'b1);
    check("stray_fill_words", 16'(wr_addr_log.size()), 16'd8);
    if (wr_addr_log.size() == 8) begin
      check("stray_fill_addr0", wr_addr_log[0], 16'h4C20);
      check("stray_fill_data0", wr_data_log[0], 16'hA000);
    end

    // Reset after three data writes
    clear_logs();
    cycle(1'b1, 16'h2468, 1'b0, 1'b0);
    g = 0;
    while (m_recv < 3 && g < 50) begin
      cycle(1'b1, 16'h2468, 1'b0, 1'b0);
      g++;
    end
    check("abort_writes_before_rst", 16'(wr_addr_log.size()), 16'd3);
    cycle(1'b0, 16'h0, 1'b0, 1'b1);
    clear_logs();
    for (int i = 0; i < 12; i++) cycle(1'b0, 16'h0, 1'b0, 1'b0);
    check("abort_late_writes", 16'(wr_addr_log.size()), 16'd0);
    check("abort_tag_writes",  16'(tag_log.size()),     16'd0);
    check("abort_busy",        16'(busy_cnt),           16'd0);
    run_fill(16'h3000, 1'b1);
    check("abort_refill_words", 16'(wr_addr_log.size()), 16'd8);
    if (wr_addr_log.size() == 8) check("abort_refill_addr0", wr_addr_log[0], 16'h3000);

    // Back-to-back misses at the top and bottom of the address space
    clear_logs();
    run_fill(16'hFFF0, 1'b1);
    run_fill(16'h0000, 1'b0);
    check("b2b_req_count", 16'(req_log.size()), 16'd16);
    if (req_log.size() == 16) begin
      check("b2b_req_7",  req_log[7],  16'hFFFE);
      check("b2b_req_8",  req_log[8],  16'h0000);
      check("b2b_req_15", req_log[15], 16'h000E);
    end
    check("b2b_tag_count", 16'(tag_log.size()), 16'd2);
    if (tag_log.size() == 2) begin
      check("b2b_tag_0", tag_log[0], 16'h00FE);
      check("b2b_tag_1", tag_log[1], 16'h0002);
    end
    if (wr_addr_log.size() == 16) check("b2b_wr_8", wr_addr_log[8], 16'h0000);

    // Random misses with in-order, variable-latency memory
    rand_lat = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      gap = $urandom_range(0, 3);
      for (int j = 0; j < gap; j++) cycle(1'b0, 16'h0, 1'b0, 1'b0);
      clear_logs();
      ra = 16'($urandom);
      run_fill(ra, 1'($urandom_range(0, 1)));
      check("rand_data_writes", 16'(wr_addr_log.size()), 16'd8);
      check("rand_tag_writes",  16'(tag_log.size()),     16'd1);
    end
    check("rand_exclusive", 16'(both_cnt), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling controller for the 2KB 2-way set-associative cache (I-cache or D-cache instance). On a cache miss it stalls the requester and fetches the 16-byte line (8 words) from multi-cycle main memory with pipelined read requests. Each returned word is written into the cache data array. After the last word it issues a single tag-array write that installs the new tag and valid bit. One instance sits beside each cache, between the cache core and the memory port (or the memory arbiter).

## Interface
- MEM_LATENCY, 4: cycles from an accepted read request to its data_valid; the memory is pipelined and accepts one request per cycle.
- WORDS_PER_LINE, 8: 16-bit words per cache line; fixed by the 16-byte line, so the block is not required to support other values.

- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- miss_detected  in  1  cache lookup of current address missed; held by the requester while fsm_busy=1.
- miss_address  in  16  byte address of the missing access; sampled only on IDLE→FILL.
- memory_data_valid  in  1  a read word is on memory_data this cycle.
- memory_data  in  16  returned read word.
- fsm_busy  out  1  stall request to the pipeline.
- memory_read_en  out  1  read request to memory this cycle.
- memory_address  out  16  byte address of the request.
- write_data_array  out  1  write one word into the cache data array.
- write_tag_array  out  1  write the metadata array for the set.
- cache_addr  out  16  address presented to the cache during a fill write.
- cache_data_in  out  16  word to write; equals memory_data.
- tag_out  out  8  new tag entry: {base[15:10], 1'b1 (valid), 1'b0}.

## Operation
- States:
  - IDLE: no fill in progress.
  - FILL: issuing read requests and collecting returned words.
  - TAG: single-cycle tag-array write.
- Registers:
  - base[15:0]: line base address.
  - issue_cnt[3:0]: requests issued, 0..8.
  - recv_cnt[3:0]: words received, 0..8.
- IDLE:
  - fsm_busy = miss_detected (combinational, so the stall takes effect in the miss cycle). All other outputs are 0.
  - If miss_detected: base ← {miss_address[15:4], 4'h0}, issue_cnt ← 0, recv_cnt ← 0, go to FILL.
- FILL:
  - fsm_busy = 1.
  - memory_read_en = (issue_cnt < 8); memory_address = base + {issue_cnt, 1'b0}; issue_cnt increments on each issue.
  - When memory_data_valid=1:
    - write_data_array = 1.
    - cache_addr = base + {recv_cnt, 1'b0}.
    - cache_data_in = memory_data.
    - recv_cnt increments.
  - When the 8th word is written (recv_cnt==7 and valid), go to TAG.
- TAG:
  - fsm_busy = 1, write_tag_array = 1, cache_addr = base, tag_out as defined above.
  - Next state is IDLE.
- Data and tag writes never coincide. The data writes complete before the tag write, so eviction way selection (driven by LRU) stays constant for the whole line. The tag write then updates the LRU bits.
- memory_address and cache_addr are 0 whenever they are not qualified by their enable.
- Address arithmetic is 16-bit. Offsets stay within bits [3:0], so there is no carry into the tag/index bits.

## Timing
- Reset: state=IDLE, counters=0, base=0. All outputs are 0, except that fsm_busy follows miss_detected in IDLE.
- Let T be the miss cycle in IDLE.
- With MEM_LATENCY=4:
  - FILL runs T+1..T+12.
  - Requests at T+1..T+8 (offsets 0x0..0xE).
  - Data writes at T+5..T+12.
  - TAG at T+13.
  - IDLE at T+14, where the cache re-lookup hits and fsm_busy drops.
- General: a fill occupies 1 + 8 + MEM_LATENCY + 1 cycles after T (fsm_busy high from T through T+9+MEM_LATENCY).
- memory_data_valid in IDLE or TAG is ignored: no write and no counter change.
- A valid beyond the 8th word in FILL cannot occur, because the transition to TAG happens on the 8th.
- Reset during FILL or TAG:
  - Next cycle is IDLE, counters cleared, no write_tag_array.
  - Partially written line words remain, but the tag is not validated.
  - Late returns from memory are ignored.
- miss_detected is not re-sampled during FILL/TAG. A new miss is recognised only in IDLE.
- A miss_detected deasserting mid-fill (e.g. a flush) does not abort the fill.

## Test plan
- Reset then idle: rst=1 for 2 cycles, miss_detected=0 → all outputs 0, no memory_read_en for 20 cycles.
- Single fill, miss_address=0x1236, memory model latency 4 returning word 0xA000+offset:
  - Requests at addresses 0x1230,0x1232,…,0x123E on 8 consecutive cycles.
  - write_data_array with cache_addr 0x1230..0x123E and data 0xA000..0xA00E.
  - write_tag_array one cycle later with tag_out=0x12 (tag 0x04, valid 1).
  - fsm_busy high 14 cycles total.
- Stray valid: pulse memory_data_valid in IDLE → no write_data_array, and the next fill still writes exactly 8 words starting at offset 0.
- Reset mid-fill after 3 data writes → IDLE next cycle, no write_tag_array, and remaining memory returns ignored.
- Back-to-back misses at 0xFFF0 then 0x0000:
  - Second fill starts only after TAG.
  - Second fill's base is 0x0000, and 0xFFFE+2 does not leak into the second fill's addresses.
- Tag/data exclusivity: across 1000 random misses and random-latency-consistent memory, write_data_array & write_tag_array is never 1 in the same cycle, and each fill has exactly 8 data writes and 1 tag write.
